exec_controller: RTL and testbench

Execution controller for the single-cycle RV32I core. It generates the core's instruction-commit enable `cpu_en`, which qualifies the PC, register-file and data-memory write updates on `clk`. It supports halt, single-step, free run at a divided rate, a PC breakpoint and EBREAK trapping, and it counts retired instructions. The block sits between the board switches/buttons and the core; the VGA debug view displays `state`, `brk_cause` and `retired`.

---
 rtl/exec_controller.sv | 154 +++++++++++++++
 tb/tb_exec_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// Execution controller for the single-cycle RV32I core: produces the commit enable
// and handles halt, single-step, divided free run, PC breakpoint and EBREAK trapping.
module exec_controller #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [1:0]  brk_cause,
    output logic [31:0] retired
);

    localparam int unsigned      DIV_W       = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(RUN_DIV - 1);
    localparam logic [31:0]      EBREAK_INSN = 32'h0010_0073;
    localparam int               SYNC_STAGES = 2;
    localparam logic [1:0]       CAUSE_NONE  = 2'b00;
    localparam logic [1:0]       CAUSE_BP    = 2'b01;
    localparam logic [1:0]       CAUSE_EB    = 2'b10;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t                 state_reg, state_next;
    logic [DIV_W-1:0]       divcnt_reg, divcnt_next;
    logic                   skip_reg, skip_next;
    logic [1:0]             brk_cause_reg, brk_cause_next;
    logic [31:0]            retired_reg, retired_next;
    logic [SYNC_STAGES-1:0] run_sync_reg, run_sync_next;
    logic [SYNC_STAGES-1:0] step_sync_reg, step_sync_next;
    logic                   step_q_reg;
    logic                   run_s, step_s, step_rise;
    logic                   div_term, hit_bp, hit_eb;

    // Synchronizer chains: stage 0 samples the pin, later stages shift.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign run_sync_next[gi]  = run_sw;
                assign step_sync_next[gi] = step_btn;
            end else begin : g_chain
                assign run_sync_next[gi]  = run_sync_reg[gi-1];
                assign step_sync_next[gi] = step_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_reg  <= '0;
            step_sync_reg <= '0;
            step_q_reg    <= 1'b0;
        end else begin
            run_sync_reg  <= run_sync_next;
            step_sync_reg <= step_sync_next;
            step_q_reg    <= step_s;
        end
    end

    assign run_s     = run_sync_reg[SYNC_STAGES-1];
    assign step_s    = step_sync_reg[SYNC_STAGES-1];
    assign step_rise = step_s & ~step_q_reg;
    assign div_term  = (divcnt_reg == DIV_LAST);
    assign hit_bp    = bp_en & (pc == bp_addr) & ~skip_reg;
    assign hit_eb    = (instruction == EBREAK_INSN) & ~skip_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_HALT;
            divcnt_reg    <= '0;
            skip_reg      <= 1'b0;
            brk_cause_reg <= CAUSE_NONE;
            retired_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            divcnt_reg    <= divcnt_next;
            skip_reg      <= skip_next;
            brk_cause_reg <= brk_cause_next;
            retired_reg   <= retired_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        divcnt_next    = divcnt_reg;
        skip_next      = skip_reg;
        brk_cause_next = brk_cause_reg;
        case (state_reg)
            ST_HALT: begin
                if (run_s) begin
                    state_next     = ST_RUN;
                    divcnt_next    = '0;
                    skip_next      = 1'b1;
                    brk_cause_next = CAUSE_NONE;
                end else if (step_rise) begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: state_next = ST_HALT;
            ST_RUN: begin
                if (!run_s) begin
                    state_next = ST_HALT;
                end else if (div_term) begin
                    divcnt_next = '0;
                    if (hit_bp) begin
                        state_next     = ST_BREAK;
                        brk_cause_next = CAUSE_BP;
                    end else if (hit_eb) begin
                        state_next     = ST_BREAK;
                        brk_cause_next = CAUSE_EB;
                    end else begin
                        // First issue after entry executes past the stopping instruction.
                        skip_next = 1'b0;
                    end
                end else begin
                    divcnt_next = divcnt_reg + DIV_W'(1);
                end
            end
            ST_BREAK: begin
                if (!run_s) begin
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        case (state_reg)
            ST_STEP: cpu_en = 1'b1;
            ST_RUN:  cpu_en = run_s & div_term & ~hit_bp & ~hit_eb;
            default: cpu_en = 1'b0;
        endcase
    end

    assign retired_next = retired_reg + 32'(cpu_en);
    assign state        = state_reg;
    assign brk_cause    = brk_cause_reg;
    assign retired      = retired_reg;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller: acts as a trivial core (pc += 4 per commit) and
// checks every commit's pc and edge number against a scoreboard of expected commits.
module tb_exec_controller;

    localparam int          RUN_DIV = 4;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] pc = '0;
    logic [31:0] instruction = NOP;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  brk_cause;
    logic [31:0] retired;

    logic        eb_en = 1'b0;
    logic [31:0] eb_addr = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          edges = 0;

    typedef struct {
        logic [31:0] pc;
        int          at_edge;
    } commit_t;
    commit_t sb[$];

    always #5 clk = ~clk;

    exec_controller #(.RUN_DIV(RUN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .instruction(instruction),
        .cpu_en     (cpu_en),
        .state      (state),
        .brk_cause  (brk_cause),
        .retired    (retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (eb_en && a == eb_addr) ? EBREAK : NOP;
    endfunction

    // One clock: sample cpu_en mid-cycle, score any commit, then advance the core model.
    task automatic tick();
        logic    en;
        commit_t c;
        @(negedge clk);
        en = cpu_en;
        if (en) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_commit: observed commit at edge %0d pc %h, expected none", edges, pc);
            end
            if (sb.size() != 0) begin
                c = sb.pop_front();
                check("commit_pc", pc, c.pc);
                check("commit_edge", 32'(edges), 32'(c.at_edge));
            end
        end
        @(posedge clk);
        edges++;
        #1;
        if (en) pc = pc + 32'd4;
        instruction = imem(pc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input bit chk);
        rst_n    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        #1;
        if (chk) begin
            check("rst_state", 32'(state), 32'd0);
            check("rst_cpu_en", 32'(cpu_en), 32'd0);
            check("rst_retired", retired, 32'd0);
            check("rst_brk_cause", 32'(brk_cause), 32'd0);
        end
        pc = '0;
        instruction = imem(pc);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
    endtask

    // Raise run_sw now; the first issue lands RUN_DIV cycles after RUN entry (2 edges later).
    task automatic start_run(input int n_commit);
        int e0;
        e0 = edges;
        for (int j = 0; j < n_commit; j++)
            sb.push_back('{pc + 32'(4 * j), e0 + 2 + RUN_DIV + RUN_DIV * j});
        run_sw = 1'b1;
    endtask

    task automatic stop_run();
        run_sw = 1'b0;
        ticks(4);
    endtask

    initial begin
        // Reset state
        do_reset(1'b1);

        // Single step: button held 10 cycles gives exactly one commit 3 edges after sampling
        sb.push_back('{pc, edges + 3});
        step_btn = 1'b1;
        ticks(10);
        step_btn = 1'b0;
        ticks(3);
        check("step_drained", 32'(sb.size()), 32'd0);
        check("step_retired", retired, 32'd1);
        check("step_state", 32'(state), 32'd0);

        // Counter wrap
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        sb.push_back('{pc, edges + 3});
        step_btn = 1'b1;
        ticks(4);
        check("wrap_retired", retired, 32'd0);
        step_btn = 1'b0;
        ticks(3);

        // Free run, 40 cycles of run_sw: issues at entry+3, +7, ... -> 9 commits
        start_run(9);
        ticks(3);
        check("run_state", 32'(state), 32'd1);
        ticks(37);
        stop_run();
        check("run_drained", 32'(sb.size()), 32'd0);
        check("run_retired", retired, 32'd9);
        check("run_halted", 32'(state), 32'd0);

        // Reset mid-RUN with retired = 5 while an issue is in progress
        do_reset(1'b0);
        start_run(5);
        ticks(26);
        check("midrun_retired", retired, 32'd5);
        check("midrun_cpu_en", 32'(cpu_en), 32'd1);
        do_reset(1'b1);

        // Breakpoint at 0x10
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        start_run(4);
        ticks(30);
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_state", 32'(state), 32'd3);
        check("bp_cause", 32'(brk_cause), 32'd1);
        check("bp_retired", retired, 32'd4);
        check("bp_pc", pc, 32'h10);
        stop_run();
        check("bp_halt_state", 32'(state), 32'd0);
        check("bp_cause_held", 32'(brk_cause), 32'd1);
        // Resume executes past the breakpoint
        start_run(4);
        ticks(4);
        check("resume_cause_clr", 32'(brk_cause), 32'd0);
        ticks(16);
        stop_run();
        check("resume_drained", 32'(sb.size()), 32'd0);
        check("resume_retired", retired, 32'd8);
        check("resume_pc", pc, 32'h20);
        bp_en = 1'b0;

        // EBREAK at 0x8, then step button in BREAK is ignored
        do_reset(1'b0);
        eb_en   = 1'b1;
        eb_addr = 32'h8;
        instruction = imem(pc);
        start_run(2);
        ticks(20);
        check("eb_state", 32'(state), 32'd3);
        check("eb_cause", 32'(brk_cause), 32'd2);
        check("eb_retired", retired, 32'd2);
        step_btn = 1'b1;
        ticks(10);
        check("eb_step_state", 32'(state), 32'd3);
        check("eb_step_retired", retired, 32'd2);
        step_btn = 1'b0;
        ticks(2);
        stop_run();
        check("eb_halt_state", 32'(state), 32'd0);
        check("eb_cause_held", 32'(brk_cause), 32'd2);

        // Breakpoint and EBREAK on the same instruction: breakpoint wins
        do_reset(1'b0);
        bp_en   = 1'b1;
        bp_addr = 32'h8;
        start_run(2);
        ticks(20);
        check("prio_state", 32'(state), 32'd3);
        check("prio_cause", 32'(brk_cause), 32'd1);
        stop_run();
        bp_en = 1'b0;
        eb_en = 1'b0;

        // run_sw and step_btn rise together in HALT: RUN wins, no STEP cycle
        do_reset(1'b0);
        start_run(1);
        step_btn = 1'b1;
        ticks(3);
        check("simul_state", 32'(state), 32'd1);
        ticks(5);
        stop_run();
        step_btn = 1'b0;
        ticks(2);
        check("simul_drained", 32'(sb.size()), 32'd0);
        check("simul_retired", retired, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
